dpram_port_arb: RTL and testbench
=================================

// Module: dpram_port_arb
// PURPOSE
//  Two-requester round-robin arbiter that shares one 32-bit port (en/we/wem/addr/din/dout)
//  of the on-chip dual-port RAM. It serializes requester transactions onto that port, with
//  byte-masked writes and registered read responses under valid/ready backpressure.
//  Typical use: core data bus (m0) and debug/ISP loader (m1) sharing port B of the SRAM.
// PARAMETERS
//  RAM_DEPTH  2048  words in the attached RAM; AW = clogb2(RAM_DEPTH-1) address bits
//  RR_EN      1     1 = round-robin; 0 = fixed priority, m0 always wins
// PORTS
//  clk            input   1   single clock; all logic on posedge
//  rst_n          input   1   asynchronous, active-low reset
//  m0_req,m1_req  input   1   request valid; held with fields stable until gnt
//  m0_we,m1_we    input   1   1 = write, 0 = read
//  m0_wem,m1_wem  input   4   byte write mask (bit i -> bits 8i+7:8i); ignored on read
//  m0_addr,m1_addr input  AW  word address
//  m0_wdata,m1_wdata input 32 write data
//  m0_gnt,m1_gnt  output  1   combinational; request accepted this cycle
//  m0_rvalid,m1_rvalid output 1 read data valid for that requester
//  m0_rdata,m1_rdata output 32 read data (shared register, qualified by own rvalid)
//  m0_rready,m1_rready input 1 requester accepts read data
//  ram_en         output  1   RAM port enable
//  ram_we         output  1   RAM port write enable
//  ram_wem        output  4   RAM byte mask = wem & {4{we}} of granted requester
//  ram_addr       output  AW  RAM address of granted requester
//  ram_din        output  32  RAM write data of granted requester
//  ram_dout       input   32  RAM read data, valid one cycle after a read enable
// BEHAVIOUR
//  Reset: state=IDLE, rvalid=0 both, rdata reg=0, owner=0, last_gnt=m1 (so m0 wins first).
//  Outputs ram_en/ram_we/ram_wem=0 and gnt=0 whenever no grant is issued.
//  ram_addr/ram_din are mux outputs of the selected requester, don't-care when ram_en=0.
//  FSM states: IDLE, RD (read issued, RAM data returns), RSP (rvalid high to owner).
//  Grant window: state==IDLE, or state==RSP with owner's rready=1 in that cycle.
//  Selection in window: one requester -> it; both -> the one != last_gnt (RR_EN=1) or m0.
//  Grant cycle T: gnt=1, ram_en=1, ram_we=we; last_gnt<=winner.
//  Write grant: no response; next state IDLE. One write per cycle sustained.
//  Read grant: owner<=winner; next RD. In RD (T+1): no grant, latch ram_dout into rdata,
//   next RSP. In RSP (T+2 on): owner's rvalid=1 until rready; other rvalid=0.
//  RSP & rready & new grant: response retires and new access issues in same cycle.
//  RSP & rready & no request -> IDLE. RSP & !rready: stay, rdata/rvalid stable, no grant.
//  Read throughput: 1 per 2 cycles with rready held high; read latency gnt->rvalid = 2.
//  Requests are not reordered; a requester sees its responses in issue order.
//  Deasserted req in grant window forfeits; no grant is ever given to req=0.
//  wem=0 on write: RAM access still issued (no bytes change), gnt returned normally.
//  Coherence with the RAM's other port is not handled here.
//  Async reset mid-read (RD/RSP): outstanding response discarded, outputs to reset values.
// TESTING
//  1. m0 write addr 5 data 0xA1B2C3D4 wem 4'hF, then read addr 5 -> m0_gnt each, rvalid 2 cyc after read gnt, rdata 0xA1B2C3D4.
//  2. Write addr 5 wem 4'b0010 data 0x0000EE00 after test 1 -> readback 0xA1B2EED4.
//  3. m0,m1 reads held high 8 txns, rready=1 -> grants alternate m0,m1,m0... first m0; each rvalid routed only to owner.
//  4. m0 read, m0_rready=0 for 5 cycles -> rvalid,rdata stable; m1_req meanwhile gets no gnt until rready=1 cycle.
//  5. RR_EN=0, both requesting writes continuously -> m0_gnt every cycle, m1_gnt never.
//  6. Assert rst_n=0 in RD state -> rvalid=0 and ram_en=0 immediately; after release m0 wins first contested grant.

Source files
------------

// File: rtl/dpram_port_arb.sv
// rtl/dpram_port_arb.sv - two-requester round-robin arbiter for one 32-bit dual-port RAM port
module dpram_port_arb #(
    parameter int RAM_DEPTH = 2048,
    parameter bit RR_EN     = 1'b1,
    localparam int AW       = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_wem,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m0_rready,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_wem,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    input  logic          m1_rready,

    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;        // 0 = m0, 1 = m1
    logic        last_gnt_q, last_gnt_d;  // requester granted most recently
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rvalid_q, rvalid_d;      // bit 0 -> m0, bit 1 -> m1

    logic        owner_rready;
    logic        window;
    logic        pick_m1;
    logic        gnt_any;
    logic        sel_we;
    logic [3:0]  sel_wem;

    // Grant window and winner selection; the loser of a tie is the one granted last time
    always_comb begin
        owner_rready = owner_q ? m1_rready : m0_rready;
        window       = (state_q == ST_IDLE) || ((state_q == ST_RSP) && owner_rready);
        if (m0_req && m1_req) begin
            pick_m1 = RR_EN ? (last_gnt_q == 1'b0) : 1'b0;
        end else begin
            pick_m1 = m1_req;
        end
        gnt_any = window && (m0_req || m1_req);
        sel_we  = pick_m1 ? m1_we  : m0_we;
        sel_wem = pick_m1 ? m1_wem : m0_wem;
    end

    // RAM port drive: enables are forced low whenever nothing is granted
    always_comb begin
        m0_gnt   = gnt_any && !pick_m1;
        m1_gnt   = gnt_any && pick_m1;
        ram_en   = gnt_any;
        ram_we   = gnt_any && sel_we;
        ram_wem  = (gnt_any && sel_we) ? sel_wem : 4'h0;
        ram_addr = pick_m1 ? m1_addr  : m0_addr;
        ram_din  = pick_m1 ? m1_wdata : m0_wdata;
    end

    // Next-state: reads walk IDLE/RSP -> RD -> RSP, writes never leave the grant window
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;

        if (gnt_any) begin
            last_gnt_d = pick_m1;
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_any && !sel_we) begin
                    owner_d = pick_m1;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                rdata_d  = ram_dout;
                rvalid_d = owner_q ? 2'b10 : 2'b01;
                state_d  = ST_RSP;
            end
            ST_RSP: begin
                if (owner_rready) begin
                    rvalid_d = 2'b00;
                    if (gnt_any && !sel_we) begin
                        owner_d = pick_m1;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                rvalid_d = 2'b00;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any outstanding response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata_q    <= 32'h0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;

endmodule

// File: tb/tb_dpram_port_arb.sv
// tb/tb_dpram_port_arb.sv - self-checking bench for dpram_port_arb
module tb_dpram_port_arb;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_we, m0_rready, m1_req, m1_we, m1_rready;
    logic [3:0]    m0_wem, m1_wem;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;

    logic          fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
    logic [31:0]   fp_m0_rdata, fp_m1_rdata;
    logic          fp_ram_en, fp_ram_we;
    logic [3:0]    fp_ram_wem;
    logic [AW-1:0] fp_ram_addr;
    logic [31:0]   fp_ram_din, fp_ram_dout;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram_mem [0:2047];
    logic [31:0] ref_mem [0:2047];
    int          exp_last;
    logic [31:0] obs_rd;

    assign fp_ram_dout = 32'h0;

    dpram_port_arb u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    dpram_port_arb #(.RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_rready(m0_rready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_rready(m1_rready),
        .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_wem(fp_ram_wem), .ram_addr(fp_ram_addr),
        .ram_din(fp_ram_din), .ram_dout(fp_ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM attached to the arbitrated port
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_wem[i]) ram_mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Expected winner: -1 none, 0 m0, 1 m1; a tie goes to whoever was not granted last
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (exp_last == 1) ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // One arbitration: drive both requesters, check the grant, complete any read
    task automatic step(input bit r0, input bit r1, input bit we0, input bit we1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] w0, input logic [3:0] w1);
        int            w;
        bit            we;
        logic [AW-1:0] wa;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_wem = w0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_wem = w1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        #1;
        w = pick(r0, r1);
        we = (w == 1) ? we1 : we0;
        wa = (w == 1) ? a1 : a0;
        chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
        chk("ram_en", 32'(ram_en), 32'(w >= 0));
        if (w >= 0) begin
            chk("ram_we", 32'(ram_we), 32'(we));
            chk("ram_addr", 32'(ram_addr), 32'(wa));
            chk("ram_wem", 32'(ram_wem), we ? 32'((w == 1) ? w1 : w0) : 32'h0);
            if (we) begin
                chk("ram_din", ram_din, (w == 1) ? d1 : d0);
                ref_mem[wa] = merge(ref_mem[wa], (w == 1) ? d1 : d0, (w == 1) ? w1 : w0);
            end
            exp_last = w;
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        if (w >= 0 && !we) begin
            #1;
            chk("rd_rvalid0", 32'({m1_rvalid, m0_rvalid}), 32'h0);
            tick();
            #1;
            chk("rsp_m0_rvalid", 32'(m0_rvalid), 32'(w == 0));
            chk("rsp_m1_rvalid", 32'(m1_rvalid), 32'(w == 1));
            obs_rd = (w == 1) ? m1_rdata : m0_rdata;
            chk("rsp_rdata", obs_rd, ref_mem[wa]);
            tick();
            #1;
            chk("retired_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        end
    endtask

    initial begin
        logic [31:0]   dat0 [0:7];
        logic [31:0]   dat1 [0:7];
        int            i0, i1, w, prev, guard;
        logic [AW-1:0] a0, a1, prev_a;
        logic [31:0]   d;
        logic [3:0]    wm;

        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_wem = 0; m0_addr = 0; m0_wdata = 0; m0_rready = 1;
        m1_req = 0; m1_we = 0; m1_wem = 0; m1_addr = 0; m1_wdata = 0; m1_rready = 1;
        for (int k = 0; k < 2048; k++) ref_mem[k] = 32'h0;
        exp_last = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        chk("rst_rdata", m0_rdata, 32'h0);
        chk("rst_ram_en", 32'({ram_en, ram_we, ram_wem}), 32'h0);
        chk("rst_fp_rvalid", 32'({fp_m1_rvalid, fp_m0_rvalid, fp_ram_en}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Contested continuous writes fill words 0..15; RR alternates, fixed priority always m0
        for (int k = 0; k < 8; k++) begin
            dat0[k] = $urandom;
            dat1[k] = $urandom;
        end
        i0 = 0; i1 = 0; guard = 0;
        m0_we = 1; m1_we = 1; m0_wem = 4'hF; m1_wem = 4'hF;
        while ((i0 < 8 || i1 < 8) && guard < 20) begin
            guard++;
            m0_req = (i0 < 8); m0_addr = AW'(i0 & 7);     m0_wdata = dat0[i0 & 7];
            m1_req = (i1 < 8); m1_addr = AW'(8 + (i1 & 7)); m1_wdata = dat1[i1 & 7];
            #1;
            w = pick(m0_req, m1_req);
            chk("fill_m0_gnt", 32'(m0_gnt), 32'(w == 0));
            chk("fill_m1_gnt", 32'(m1_gnt), 32'(w == 1));
            chk("fill_addr", 32'(ram_addr), (w == 1) ? 32'(m1_addr) : 32'(m0_addr));
            if (m0_req && m1_req) begin
                chk("fp_m0_gnt", 32'(fp_m0_gnt), 32'h1);
                chk("fp_m1_gnt", 32'(fp_m1_gnt), 32'h0);
            end
            if (w == 0) begin ref_mem[m0_addr] = m0_wdata; i0++; end
            if (w == 1) begin ref_mem[m1_addr] = m1_wdata; i1++; end
            exp_last = w;
            tick();
        end
        chk("fill_done", 32'(guard), 32'd16);
        m0_req = 0; m1_req = 0;

        // Full-word write then readback, then a single-byte patch
        step(1, 0, 1, 0, 11'd5, 11'd0, 32'hA1B2C3D4, 32'h0, 4'hF, 4'h0);
        step(1, 0, 0, 0, 11'd5, 11'd0, 32'h0, 32'h0, 4'hF, 4'h0);
        chk("t1_rdata", obs_rd, 32'hA1B2C3D4);
        step(1, 0, 1, 0, 11'd5, 11'd0, 32'h0000EE00, 32'h0, 4'b0010, 4'h0);
        step(1, 0, 0, 0, 11'd5, 11'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        chk("t2_rdata", obs_rd, 32'hA1B2EED4);
        step(0, 1, 0, 1, 11'd0, 11'd6, 32'h0, 32'h12345678, 4'h0, 4'h0);
        step(0, 1, 0, 0, 11'd0, 11'd6, 32'h0, 32'h0, 4'h0, 4'h0);

        // Back-to-back contested reads with rready held: grants alternate, retire and issue overlap
        m0_we = 0; m1_we = 0; m0_rready = 1; m1_rready = 1;
        a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
        m0_req = 1; m1_req = 1;
        prev = -1; prev_a = '0;
        for (int k = 0; k < 8; k++) begin
            m0_addr = a0; m1_addr = a1;
            #1;
            w = pick(1, 1);
            chk("rr_m0_gnt", 32'(m0_gnt), 32'(w == 0));
            chk("rr_m1_gnt", 32'(m1_gnt), 32'(w == 1));
            chk("rr_m0_rvalid", 32'(m0_rvalid), 32'(prev == 0));
            chk("rr_m1_rvalid", 32'(m1_rvalid), 32'(prev == 1));
            if (prev >= 0) chk("rr_rdata", (prev == 1) ? m1_rdata : m0_rdata, ref_mem[prev_a]);
            exp_last = w; prev = w; prev_a = (w == 1) ? a1 : a0;
            tick();
            if (w == 0) a0 = AW'($urandom_range(0, 15)); else a1 = AW'($urandom_range(0, 15));
            m0_addr = a0; m1_addr = a1;
            #1;
            chk("rr_rd_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
            chk("rr_rd_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
            tick();
        end
        m0_req = 0; m1_req = 0;
        #1;
        chk("rr_last_rvalid", 32'({m1_rvalid, m0_rvalid}), (prev == 1) ? 32'h2 : 32'h1);
        chk("rr_last_rdata", m0_rdata, ref_mem[prev_a]);
        tick();
        #1;
        chk("rr_idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);

        // Backpressure: m0 holds its response, m1 write waits for the rready cycle
        m0_req = 1; m0_we = 0; m0_addr = 11'd7; m0_rready = 1;
        #1;
        chk("bp_gnt", 32'(m0_gnt), 32'h1);
        exp_last = 0;
        tick();
        m0_req = 0; m0_rready = 0;
        tick();
        d = $urandom; wm = 4'(1 + $urandom_range(0, 14));
        m1_req = 1; m1_we = 1; m1_addr = 11'd9; m1_wdata = d; m1_wem = wm;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rvalid", 32'(m0_rvalid), 32'h1);
            chk("bp_rdata", m0_rdata, ref_mem[7]);
            chk("bp_m1_gnt", 32'(m1_gnt), 32'h0);
            chk("bp_ram_en", 32'(ram_en), 32'h0);
            tick();
        end
        m0_rready = 1;
        #1;
        chk("bp_rel_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("bp_rel_rvalid", 32'(m0_rvalid), 32'h1);
        chk("bp_rel_wem", 32'(ram_wem), 32'(wm));
        ref_mem[9] = merge(ref_mem[9], d, wm);
        exp_last = 1;
        tick();
        m1_req = 0;
        #1;
        chk("bp_after_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);

        // Randomized mixed traffic over words 0..15
        for (int k = 0; k < 40; k++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                 $urandom, $urandom, 4'($urandom), 4'($urandom));
        end
        step(1, 0, 0, 0, 11'd9, 11'd0, 32'h0, 32'h0, 4'h0, 4'h0);

        // Reset while a read is in RD: response dropped, m0 wins first tie afterwards
        m0_req = 1; m0_we = 0; m0_addr = 11'd3; m1_req = 0;
        #1;
        chk("rst_rd_gnt", 32'(m0_gnt), 32'h1);
        tick();
        m0_req = 0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        chk("arst_ram_en", 32'(ram_en), 32'h0);
        chk("arst_rdata", m0_rdata, 32'h0);
        tick();
        tick();
        #1;
        chk("arst_hold_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        rst_n = 1'b1;
        exp_last = 1;
        tick();
        step(1, 1, 0, 0, 11'd1, 11'd2, 32'h0, 32'h0, 4'h0, 4'h0);
        step(1, 1, 1, 1, 11'd1, 11'd2, $urandom, $urandom, 4'hF, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
